// File: rtl/branch_cond_pkg.sv
// Shared branch-condition definitions: condition codes, CCR bit positions, FSM states.
// Imported by the branch unit and by the decode stage's static predictor.
package branch_cond_pkg;

  localparam int NCOND    = 4;
  localparam int FLAG_LAT = 1;

  localparam logic [NCOND-1:0] COND_BRA  = 4'd0;
  localparam logic [NCOND-1:0] COND_BEQ  = 4'd1;
  localparam logic [NCOND-1:0] COND_BNE  = 4'd2;
  localparam logic [NCOND-1:0] COND_BLTU = 4'd3;
  localparam logic [NCOND-1:0] COND_BGTU = 4'd4;
  localparam logic [NCOND-1:0] COND_BLT  = 4'd5;
  localparam logic [NCOND-1:0] COND_BGT  = 4'd6;
  localparam logic [NCOND-1:0] COND_BLEU = 4'd7;
  localparam logic [NCOND-1:0] COND_BGEU = 4'd8;
  localparam logic [NCOND-1:0] COND_BLE  = 4'd9;
  localparam logic [NCOND-1:0] COND_BGE  = 4'd10;
  localparam logic [NCOND-1:0] COND_BNV  = 4'd11;

  localparam int CCR_C = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_N = 1;
  localparam int CCR_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator over a {C,Z,N,V} flag vector.
// C is borrow on SUB, so unsigned "lower" is C=1; codes 12-15 are reserved and never taken.
module cond_eval
  import branch_cond_pkg::*;
(
  input  logic [3:0]       flags,
  input  logic [NCOND-1:0] cond,
  output logic             taken
);

  logic c, z, lt;

  assign c  = flags[CCR_C];
  assign z  = flags[CCR_Z];
  assign lt = flags[CCR_N] ^ flags[CCR_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BRA:  taken = 1'b1;
      COND_BEQ:  taken = z;
      COND_BNE:  taken = ~z;
      COND_BLTU: taken = c;
      COND_BGTU: taken = ~c & ~z;
      COND_BLT:  taken = lt;
      COND_BGT:  taken = ~lt & ~z;
      COND_BLEU: taken = c | z;
      COND_BGEU: taken = ~c;
      COND_BLE:  taken = lt | z;
      COND_BGE:  taken = ~lt;
      COND_BNV:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond.sv
// Condition-code register plus hazard-aware branch resolver; a request waits until all flag
// updates issued up to its acceptance cycle are visible. COND_FWD_EN forwards live ALU flags.
module branch_cond
  import branch_cond_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flag_issue_i,
  input  logic             alu_c_i,
  input  logic             alu_z_i,
  input  logic             alu_n_i,
  input  logic             alu_v_i,
  input  logic             br_valid_i,
  input  logic [NCOND-1:0] br_cond_i,
  output logic             br_ready_o,
  output logic             br_done_o,
  output logic             br_taken_o,
  output logic [3:0]       ccr_o
);

  state_t           state_q;
  logic             pend_q;
  logic [3:0]       ccr_q;
  logic             wcnt_q;
  logic [NCOND-1:0] cond_q;
  logic             done_q;
  logic             taken_q;

  logic [3:0]       alu_flags;
  logic [3:0]       eval_flags;
  logic [NCOND-1:0] eval_cond;
  logic             eval_taken;

  assign alu_flags = {alu_c_i, alu_z_i, alu_n_i, alu_v_i};

`ifdef COND_FWD_EN
  assign eval_flags = pend_q ? alu_flags : ccr_q;
`else
  assign eval_flags = ccr_q;
`endif

  // In IDLE the request is evaluated in its acceptance cycle; in WAIT the latched code is used.
  assign eval_cond = (state_q == ST_IDLE) ? br_cond_i : cond_q;

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (eval_cond),
    .taken (eval_taken)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      ccr_q   <= '0;
      wcnt_q  <= 1'b0;
      cond_q  <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      pend_q <= flag_issue_i;
      if (pend_q) ccr_q <= alu_flags;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (br_valid_i) begin
            cond_q <= br_cond_i;
`ifdef COND_FWD_EN
            if (flag_issue_i) begin
              state_q <= ST_WAIT;
              wcnt_q  <= 1'b0;
            end else begin
              done_q  <= 1'b1;
              taken_q <= eval_taken;
            end
`else
            if (flag_issue_i) begin
              state_q <= ST_WAIT;
              wcnt_q  <= 1'b1;
            end else if (pend_q) begin
              state_q <= ST_WAIT;
              wcnt_q  <= 1'b0;
            end else begin
              done_q  <= 1'b1;
              taken_q <= eval_taken;
            end
`endif
          end
        end
        ST_WAIT: begin
          if (!wcnt_q) begin
            done_q  <= 1'b1;
            taken_q <= eval_taken;
            state_q <= ST_IDLE;
          end else begin
            wcnt_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign br_ready_o = (state_q == ST_IDLE);
  assign br_done_o  = done_q;
  assign br_taken_o = taken_q;
  assign ccr_o      = ccr_q;

endmodule

// File: tb/tb_branch_cond.sv
// Directed bench for branch_cond: reset, hazard latencies, forwarding and condition sweeps.
module tb_branch_cond;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flag_issue_i;
  logic       alu_c_i, alu_z_i, alu_n_i, alu_v_i;
  logic       br_valid_i;
  logic [3:0] br_cond_i;
  logic       br_ready_o, br_done_o, br_taken_o;
  logic [3:0] ccr_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] alu_pipe = 4'h0;

`ifdef COND_FWD_EN
  localparam int LAT_ISS  = 2;
  localparam int LAT_PEND = 1;
`else
  localparam int LAT_ISS  = 3;
  localparam int LAT_PEND = 2;
`endif

  localparam logic [3:0] F_SUB35  = 4'b1010;  // C=1 Z=0 N=1 V=0
  localparam logic [3:0] F_SUB55  = 4'b0100;  // Z=1
  localparam logic [3:0] F_ADD11  = 4'b0000;
  localparam logic [3:0] F_MINM1  = 4'b0001;  // 0x80000000-1: V=1

  branch_cond dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flag_issue_i (flag_issue_i),
    .alu_c_i      (alu_c_i),
    .alu_z_i      (alu_z_i),
    .alu_n_i      (alu_n_i),
    .alu_v_i      (alu_v_i),
    .br_valid_i   (br_valid_i),
    .br_cond_i    (br_cond_i),
    .br_ready_o   (br_ready_o),
    .br_done_o    (br_done_o),
    .br_taken_o   (br_taken_o),
    .ccr_o        (ccr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: ALU outputs the flags of the op issued last cycle (registered ALU).
  // Returns at the falling edge so outputs of this cycle can be checked.
  task automatic cyc(input logic iss, input logic [3:0] opf, input logic v, input logic [3:0] c);
    @(posedge clk_i);
    #1;
    {alu_c_i, alu_z_i, alu_n_i, alu_v_i} = alu_pipe;
    flag_issue_i = iss;
    if (iss) alu_pipe = opf;
    br_valid_i = v;
    br_cond_i  = c;
    @(negedge clk_i);
  endtask

  task automatic set_ccr(input logic [3:0] f);
    cyc(1'b1, f, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic sweep(input logic [3:0] f, input logic [15:0] exp);
    set_ccr(f);
    for (int i = 0; i <= 16; i++) begin
      cyc(1'b0, 4'd0, (i < 16), 4'(i));
      if (i == 0) check("sweep_ccr", ccr_o, f);
      check("sweep_ready", br_ready_o, 1'b1);
      if (i > 0) begin
        check("sweep_done", br_done_o, 1'b1);
        check($sformatf("sweep_f%0h_c%0d", f, i - 1), br_taken_o, exp[i-1]);
      end
    end
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    check("sweep_done_end", br_done_o, 1'b0);
  endtask

  // Accept a request in cycle A (issue/valid as given) then expect done exactly lat cycles later.
  task automatic expect_done(input string tag, input int lat, input logic exp_taken,
                             input logic later_iss, input logic [3:0] later_f);
    for (int k = 1; k <= lat; k++) begin
      cyc(later_iss && (k == 1), later_f, 1'b0, 4'd0);
      if (k < lat) begin
        check({tag, "_ready_wait"}, br_ready_o, 1'b0);
        check({tag, "_done_early"}, br_done_o, 1'b0);
      end
    end
    check({tag, "_done"}, br_done_o, 1'b1);
    check({tag, "_taken"}, br_taken_o, exp_taken);
    check({tag, "_ready"}, br_ready_o, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    check({tag, "_single_pulse"}, br_done_o, 1'b0);
    check({tag, "_taken_hold"}, br_taken_o, exp_taken);
  endtask

  initial begin
    rst_ni = 1'b0;
    flag_issue_i = 1'b0;
    {alu_c_i, alu_z_i, alu_n_i, alu_v_i} = 4'h0;
    br_valid_i = 1'b0;
    br_cond_i = 4'd0;
    repeat (2) @(negedge clk_i);
    check("rst_ccr", ccr_o, 4'h0);
    check("rst_ready", br_ready_o, 1'b1);
    check("rst_done", br_done_o, 1'b0);
    check("rst_taken", br_taken_o, 1'b0);
    rst_ni = 1'b1;

    // Reset while a hazarded request is in flight: it must be dropped.
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, F_SUB55, 1'b1, 4'd1);
    check("rstw_ready_A", br_ready_o, 1'b1);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    flag_issue_i = 1'b0;
    br_valid_i = 1'b0;
    @(negedge clk_i);
    check("rstw_ccr_in_rst", ccr_o, 4'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    alu_pipe = 4'h0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'd0, 1'b0, 4'd0);
      check("rstw_no_done", br_done_o, 1'b0);
      check("rstw_ccr", ccr_o, 4'h0);
      check("rstw_ready", br_ready_o, 1'b1);
    end

    // No hazard: BEQ then BNE back-to-back on Z=1.
    set_ccr(F_SUB55);
    cyc(1'b0, 4'd0, 1'b1, 4'd1);
    check("nh_ccr", ccr_o, F_SUB55);
    check("nh_ready_A", br_ready_o, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 4'd2);
    check("nh_beq_done", br_done_o, 1'b1);
    check("nh_beq_taken", br_taken_o, 1'b1);
    check("nh_ready_A1", br_ready_o, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    check("nh_bne_done", br_done_o, 1'b1);
    check("nh_bne_taken", br_taken_o, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    check("nh_done_clear", br_done_o, 1'b0);
    check("nh_taken_hold", br_taken_o, 1'b0);

    // Issue in the acceptance cycle: SUB 3-5 then BLTU.
    cyc(1'b1, F_SUB35, 1'b1, 4'd3);
    check("iss_ready_A", br_ready_o, 1'b1);
    expect_done("iss", LAT_ISS, 1'b1, 1'b0, 4'd0);
    check("iss_ccr", ccr_o, F_SUB35);

    // Pending hazard: SUB 5-5 issued at A-1, BEQ at A (CCR still says Z=0).
    cyc(1'b1, F_SUB55, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd1);
    expect_done("pend", LAT_PEND, 1'b1, 1'b0, 4'd0);

    // Later issue (ADD 1+1, Z=0) at A+1 must not affect the request.
    set_ccr(F_SUB35);
    cyc(1'b1, F_SUB55, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd1);
    expect_done("late", LAT_PEND, 1'b1, 1'b1, F_ADD11);
    cyc(1'b0, 4'd0, 1'b0, 4'd0);
    check("late_ccr_after", ccr_o, F_ADD11);

    // Condition sweeps over all 16 codes.
    sweep(F_MINM1, 16'h0335);
    sweep(F_SUB35, 16'h02AD);
    sweep(F_SUB55, 16'h0783);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_cond.md
Name: branch_cond

Overview:
Consumer end of the ALU flag interface. Captures the ALU's C/Z/N/V outputs into a condition-code register (CCR) one cycle after each flag-setting op issues. It also serves branch-condition requests from the control unit over a valid/ready handshake. Flag hazards are resolved internally: a request is stalled until every flag update issued at or before its acceptance cycle is in the CCR.

Parameters:
NCOND, 4, width of condition-code field
FLAG_LAT, 1, cycles from flag_issue_i to ALU flags valid on alu_*_i (fixed, ALU output is registered)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flag_issue_i  in  1  flag-setting ALU op issued this cycle
alu_c_i  in  1  ALU carry/borrow, valid FLAG_LAT cycles after issue
alu_z_i  in  1  ALU zero
alu_n_i  in  1  ALU negative
alu_v_i  in  1  ALU overflow
br_valid_i  in  1  branch request valid
br_cond_i  in  NCOND  condition code
br_ready_o  out  1  request accepted when br_valid_i & br_ready_o
br_done_o  out  1  one-cycle pulse, br_taken_o valid
br_taken_o  out  1  condition result
ccr_o  out  4  current CCR {C,Z,N,V}

Behaviour:
- Reset (rst_ni low, async): CCR=0, pend_q=0, state IDLE, br_done_o=0, br_taken_o=0, br_ready_o=1 while in IDLE. A request in flight is dropped: no br_done_o pulse.
- pend_q <= flag_issue_i each cycle. When pend_q=1, CCR <= {alu_c_i,alu_z_i,alu_n_i,alu_v_i} at the clock edge. Back-to-back issues capture every cycle, in order.
- States: IDLE, WAIT.
- IDLE: br_ready_o=1. On acceptance in cycle A:
  - pend_q=0 and flag_issue_i=0: evaluate CCR in A, register result; br_done_o=1 in A+1. Stay IDLE.
  - pend_q=1, flag_issue_i=0: go WAIT with wcnt=0; evaluate CCR in A+1; done in A+2.
  - flag_issue_i=1 (any pend_q): go WAIT with wcnt=1; evaluate in A+2; done in A+3.
- WAIT: br_ready_o=0. Decrement wcnt each cycle. At wcnt=0, evaluate CCR, register result, return to IDLE.
- Issues after acceptance are ignored for that request. They cannot reach the CCR before the evaluation cycle.
- br_done_o is high for exactly one cycle per accepted request. br_taken_o holds until the next done. Throughput is one branch per cycle when there are no hazards; a new request may be accepted in the same cycle as a done pulse.
- Conditions (C = borrow on SUB): 0 BRA 1; 1 BEQ Z; 2 BNE !Z; 3 BLTU C; 4 BGTU !C&!Z; 5 BLT N^V; 6 BGT !(N^V)&!Z; 7 BLEU C|Z; 8 BGEU !C; 9 BLE (N^V)|Z; 10 BGE !(N^V); 11 BNV 0; 12-15 reserved, result 0.
- br_cond_i is sampled at acceptance and held internally; it is not re-read in WAIT.
- ccr_o is the registered CCR with no bypass.

Optional Feature:
COND_FWD_EN
- Defined: evaluation reads ccr_next, which is the live alu_*_i flags when pend_q=1, else the CCR.
  - pend_q=1 at acceptance: no wait, done in A+1.
  - flag_issue_i=1: wcnt=0, done in A+2.
  - In WAIT, the evaluation cycle also uses ccr_next.
- Undefined: latencies exactly as in Behaviour. No combinational path from alu_*_i to br_taken_o's D input.

Decomposition:
- Shared header bexkat1.vh holds:
  - condition-code localparams COND_BRA..COND_BNV;
  - CCR bit indices CCR_C=3, CCR_Z=2, CCR_N=1, CCR_V=0;
  - state encodings.
- One combinational sub-module, cond_eval (inputs: 4-bit flags, cond; output: taken). Reused by the decode stage for static prediction.

Test Plan:
- Reset mid-WAIT: issue SUB, branch accepted same cycle, drop rst_ni in A+1 -> no br_done_o, ccr_o=0, br_ready_o=1 after release.
- No hazard: CCR=Z set, br_cond=BEQ accepted at A -> br_done_o=1, br_taken_o=1 at A+1. BNE at A+1 -> taken=0 at A+2.
- Issue-same-cycle: ALU SUB 3-5 issued at A (next flags C=1,N=1,Z=0,V=0), BLTU at A -> ready low A+1..A+2, done at A+3, taken=1. With COND_FWD_EN -> done at A+2.
- Pending hazard: issue at A-1 (SUB 5-5, Z=1), BEQ at A -> done A+2 taken=1. With COND_FWD_EN -> done A+1 taken=1.
- Later issue ignored: SUB 5-5 issued at A-1, BEQ at A, ADD 1+1 issued at A+1 (Z=0) -> taken=1.
- Signed/unsigned sweep: SUB 0x80000000-1 (V=1, N=0, C=0) -> BLT taken, BLTU not taken, BGE not taken, BGEU taken; codes 12-15 -> taken=0.
